// File: rtl/alu_operand_recovery.sv
`default_nettype none
// ============================================================================
// Module  : alu_operand_recovery
// Brief   : Recovers operand A of the 4-bit ALU from result Y, select S and B,
//           with a restoring divider to invert the multiply.
// Revision: 1.0
// ============================================================================
module alu_operand_recovery #(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 8,
    parameter int SELECT_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OUTPUT_WIDTH-1:0] Y,
    input  logic [INPUT_WIDTH-1:0]  B,
    input  logic [SELECT_WIDTH-1:0] S,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INPUT_WIDTH-1:0]  A_out,
    output logic                    err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DIV  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_MUL = 2'b01;
    localparam logic [1:0] c_OP_SHL = 2'b10;
    localparam logic [1:0] c_OP_CAT = 2'b11;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_rdy_en;
    logic [7:0] r_q;
    logic [3:0] r_div;
    logic [8:0] r_rem;
    logic [3:0] r_cnt;
    logic [3:0] r_a;
    logic       r_err;
    logic       r_out_valid;

    logic       w_accept;
    logic       w_is_div;
    logic [8:0] w_diff;
    logic [7:0] w_shr;
    logic [7:0] w_mask;
    logic [3:0] w_acc_a;
    logic       w_acc_err;
    logic [8:0] w_rem_sh;
    logic       w_ge;
    logic [8:0] w_rem_nx;
    logic [7:0] w_q_nx;
    logic       w_div_last;

    assign w_accept = in_valid && in_ready;
    assign w_is_div = (S == c_OP_MUL) && (B != 4'd0);

    // Closed-form inverses for the single-cycle operations
    assign w_diff = {1'b0, Y} - {5'd0, B};
    assign w_shr  = Y >> B[2:0];
    assign w_mask = (8'd1 << B[2:0]) - 8'd1;

    always_comb begin
        w_acc_a   = 4'd0;
        w_acc_err = 1'b0;
        case (S)
            c_OP_ADD: begin
                w_acc_a   = w_diff[3:0];
                w_acc_err = w_diff[8] || (w_diff[7:0] > 8'd15);
            end
            c_OP_MUL: begin
                w_acc_err = (Y != 8'd0);
            end
            c_OP_SHL: begin
                if (B[3]) begin
                    w_acc_err = (Y != 8'd0);
                end else begin
                    w_acc_a   = w_shr[3:0];
                    w_acc_err = (w_shr[7:4] != 4'd0) || ((Y & w_mask) != 8'd0);
                end
            end
            c_OP_CAT: begin
                w_acc_a   = Y[7:4];
                w_acc_err = (Y[3:0] != B);
            end
            default: begin
                w_acc_a   = 4'd0;
                w_acc_err = 1'b0;
            end
        endcase
    end

    // One restoring-division step; r_q shifts the dividend out and the quotient in
    assign w_rem_sh   = {r_rem[7:0], r_q[7]};
    assign w_ge       = (w_rem_sh >= {5'd0, r_div});
    assign w_rem_nx   = w_ge ? (w_rem_sh - {5'd0, r_div}) : w_rem_sh;
    assign w_q_nx     = {r_q[6:0], w_ge};
    assign w_div_last = (r_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_is_div ? c_DIV : c_DONE;
                end
            end
            c_DIV: begin
                if (w_div_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_IDLE) && r_rdy_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_en    <= 1'b0;
            r_q         <= 8'd0;
            r_div       <= 4'd0;
            r_rem       <= 9'd0;
            r_cnt       <= 4'd0;
            r_a         <= 4'd0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_q   <= Y;
                        r_div <= B;
                        r_rem <= 9'd0;
                        r_cnt <= 4'd0;
                        if (!w_is_div) begin
                            r_a   <= w_acc_a;
                            r_err <= w_acc_err;
                        end
                    end
                end
                c_DIV: begin
                    r_q   <= w_q_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_div_last) begin
                        r_a   <= w_q_nx[3:0];
                        r_err <= (w_q_nx[7:4] != 4'd0) || (w_rem_nx != 9'd0);
                    end
                end
                c_DONE: begin
                    // Valid rises one edge after DONE is entered and drops on handshake
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign A_out     = r_a;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_recovery.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_operand_recovery
// Brief   : Scoreboard bench; expected operands found by brute-force search.
// Revision: 1.0
// ============================================================================
module tb_alu_operand_recovery;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] Y = 8'd0;
    logic [3:0] B = 4'd0;
    logic [1:0] S = 2'd0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] A_out;
    logic       err;

    typedef struct packed {
        logic [3:0] a;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_operand_recovery #(
        .INPUT_WIDTH (4),
        .OUTPUT_WIDTH(8),
        .SELECT_WIDTH(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Y        (Y),
        .B        (B),
        .S        (S),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .A_out    (A_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fwd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        logic [7:0] ax;
        ax = {4'd0, a};
        case (s)
            2'b00:   return ax + {4'd0, b};
            2'b01:   return ax * {4'd0, b};
            2'b10:   return ax << b;
            default: return {a, b};
        endcase
    endfunction

    // Search every A; the lowest A satisfying the forward equation wins
    function automatic exp_t model(input logic [7:0] y, input logic [3:0] b, input logic [1:0] s);
        exp_t r;
        r.a   = 4'd0;
        r.err = 1'b1;
        r.lat = (s == 2'b01 && b != 4'd0) ? 8'd9 : 8'd1;
        for (int k = 15; k >= 0; k--) begin
            if (fwd(4'(k), b, s) == y) begin
                r.a   = 4'(k);
                r.err = 1'b0;
            end
        end
        if (r.err) begin
            case (s)
                2'b00:   r.a = y[3:0] - b;
                2'b01:   r.a = (b == 4'd0) ? 4'd0 : 4'(y / {4'd0, b});
                2'b10:   r.a = (b >= 4'd8) ? 4'd0 : 4'(y >> b);
                default: r.a = y[7:4];
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] y, input logic [3:0] b, input logic [1:0] s);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        Y = y; B = b; S = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(y, b, s));
    endtask

    task automatic get_out(output logic [3:0] a, output logic e, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 60);
        a = A_out;
        e = err;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b0 || A_out !== 4'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ov=%b a=%h err=%b rdy=%b required 0 0 0 0", out_valid, A_out, err, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_mul;
        logic [7:0] ty [4] = '{8'hE1, 8'd100, 8'd0, 8'd5};
        logic [3:0] tbv [4] = '{4'd15, 4'd7, 4'd0, 4'd0};
        exp_t x; logic [3:0] a; logic e; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ty[i], tbv[i], 2'b01);
            get_out(a, e, lat);
            x = exp_q.pop_front();
            checks++;
            if (a !== x.a || e !== x.err || lat != int'(x.lat)) begin
                failures++;
                $display("FAIL mul_%0d: a=%h err=%b lat=%0d required a=%h err=%b lat=%0d", i, a, e, lat, x.a, x.err, x.lat);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mul_pulse_%0d: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_ops;
        logic [7:0] ty [8] = '{8'h14, 8'h03, 8'hA7, 8'hA7, 8'h58, 8'h59, 8'h00, 8'h80};
        logic [3:0] tbv [8] = '{4'd5, 4'd5, 4'd7, 4'd6, 4'd3, 4'd3, 4'd9, 4'd9};
        logic [1:0] ts [8] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        exp_t x; logic [3:0] a; logic e; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(ty[i], tbv[i], ts[i]);
            get_out(a, e, lat);
            x = exp_q.pop_front();
            checks++;
            if (a !== x.a || e !== x.err || lat != int'(x.lat)) begin
                failures++;
                $display("FAIL op_%0d: a=%h err=%b lat=%0d required a=%h err=%b lat=%0d", i, a, e, lat, x.a, x.err, x.lat);
            end
        end
    endtask

    task automatic test_reset_mid_div;
        logic saw = 1'b0;
        send(8'hE1, 4'd15, 2'b01);
        void'(exp_q.pop_back());
        repeat (4) begin @(posedge clk); #1; saw |= out_valid; end
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; saw |= out_valid; end
        checks++;
        if (A_out !== 4'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_div_reset: a=%h err=%b rdy=%b required 0 0 0", A_out, err, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_div_release: in_ready=%b required 1", in_ready);
        end
        repeat (12) begin @(posedge clk); #1; saw |= out_valid; end
        checks++;
        if (saw !== 1'b0) begin
            failures++;
            $display("FAIL mid_div_discard: out_valid seen=%b required 0", saw);
        end
    endtask

    task automatic test_backpressure;
        exp_t x; logic [3:0] a; logic e; int lat;
        out_ready = 1'b0;
        send(8'h14, 4'd5, 2'b00);
        get_out(a, e, lat);
        x = exp_q.pop_front();
        checks++;
        if (a !== x.a || e !== x.err || lat != int'(x.lat)) begin
            failures++;
            $display("FAIL bp_first: a=%h err=%b lat=%0d required a=%h err=%b lat=%0d", a, e, lat, x.a, x.err, x.lat);
        end
        Y = 8'h58; B = 4'd3; S = 2'b10; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || A_out !== x.a || err !== x.err || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: ov=%b a=%h err=%b rdy=%b required 1 %h %b 0", i, out_valid, A_out, err, in_ready, x.a, x.err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake: ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready);
        end
        in_valid = 1'b0;
        exp_q.push_back(model(8'h58, 4'd3, 2'b10));
        get_out(a, e, lat);
        x = exp_q.pop_front();
        checks++;
        if (a !== x.a || e !== x.err || lat != int'(x.lat)) begin
            failures++;
            $display("FAIL bp_second: a=%h err=%b lat=%0d required a=%h err=%b lat=%0d", a, e, lat, x.a, x.err, x.lat);
        end
    endtask

    task automatic test_isolation;
        exp_t x; int lat = 0;
        out_ready = 1'b1;
        send(8'hE1, 4'd15, 2'b01);
        while (out_valid !== 1'b1 && lat < 60) begin
            Y = 8'($urandom); B = 4'($urandom); S = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        x = exp_q.pop_front();
        checks++;
        if (A_out !== x.a || err !== x.err || lat != int'(x.lat)) begin
            failures++;
            $display("FAIL isolation: a=%h err=%b lat=%0d required a=%h err=%b lat=%0d", A_out, err, lat, x.a, x.err, x.lat);
        end
    endtask

    task automatic test_random;
        exp_t x; logic [3:0] a; logic e; int lat;
        logic [3:0] ra, rb; logic [1:0] rs; logic [7:0] ry;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            ry = fwd(ra, rb, rs);
            if ($urandom_range(0, 2) == 0) ry = ry ^ (8'd1 << $urandom_range(0, 7));
            send(ry, rb, rs);
            get_out(a, e, lat);
            x = exp_q.pop_front();
            checks++;
            if (a !== x.a || e !== x.err || lat != int'(x.lat)) begin
                failures++;
                $display("FAIL rand_%0d (y=%h b=%h s=%0d): a=%h err=%b lat=%0d required a=%h err=%b lat=%0d",
                         i, ry, rb, rs, a, e, lat, x.a, x.err, x.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_ops();
        test_reset_mid_div();
        test_backpressure();
        test_isolation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
